// File: rtl/mem_stage_wbuf_if.sv
// rtl/mem_stage_wbuf_if.sv - pipeline and backend signal bundle for mem_stage_wbuf
//
// Purpose:
//   Groups the EXE/MEM-side load/store handshake, the request/acknowledge
//   memory backend bus and the write-buffer status into one bundle.
//   The memory stage connects through the slave modport. The pipeline/backend
//   environment connects through the master modport.
//
// Signals:
//   mem_read   pipeline -> stage    load request, held with address until ready
//   mem_write  pipeline -> stage    store request, held with address/data until ready
//   address    pipeline -> stage    byte address
//   data       pipeline -> stage    store data
//   mem_result stage -> pipeline    load result, valid while ready=1 for a load
//   ready      stage -> pipeline    1 = stage may advance this cycle
//   be_req     stage -> backend     request, held until be_ack
//   be_we      stage -> backend     1 = write, 0 = read
//   be_addr    stage -> backend     word-aligned byte address
//   be_wdata   stage -> backend     write data
//   be_ack     backend -> stage     one-cycle completion pulse
//   be_rdata   backend -> stage     read data, valid with be_ack
//   wb_count   stage -> observer    occupied write-buffer entries
//   wb_empty   stage -> observer    wb_count == 0
interface mem_stage_wbuf_if #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int WB_DEPTH = 4
);
  localparam int CNT_W = $clog2(WB_DEPTH) + 1;

  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] data;
  logic [DATA_W-1:0] mem_result;
  logic              ready;

  logic              be_req;
  logic              be_we;
  logic [ADDR_W-1:0] be_addr;
  logic [DATA_W-1:0] be_wdata;
  logic              be_ack;
  logic [DATA_W-1:0] be_rdata;

  logic [CNT_W-1:0]  wb_count;
  logic              wb_empty;

  modport slave (
    input  mem_read, mem_write, address, data, be_ack, be_rdata,
    output mem_result, ready, be_req, be_we, be_addr, be_wdata, wb_count, wb_empty
  );

  modport master (
    output mem_read, mem_write, address, data, be_ack, be_rdata,
    input  mem_result, ready, be_req, be_we, be_addr, be_wdata, wb_count, wb_empty
  );
endinterface

// File: rtl/mem_stage_wbuf.sv
// rtl/mem_stage_wbuf.sv - memory stage with posted write buffer and read forwarding
//
// Purpose:
//   Sits between the EXE/MEM pipeline register and a request/acknowledge
//   memory backend. Stores retire into a circular write buffer without
//   stalling while it has room. Loads are served from the youngest matching
//   buffered store in the same cycle. Otherwise they go to the backend ahead
//   of the queued stores. The buffer drains one entry at a time whenever the
//   backend is otherwise idle.
//
// Ports:
//   clk  in   clock, rising edge
//   rst  in   asynchronous, active-high reset. The backend shares it, so an
//             in-flight access is simply abandoned.
//   bus  slave modport of mem_stage_wbuf_if:
//        mem_read/mem_write/address/data in, mem_result/ready out
//        be_req/be_we/be_addr/be_wdata out (registered), be_ack/be_rdata in
//        wb_count/wb_empty out
module mem_stage_wbuf #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int WB_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  mem_stage_wbuf_if.slave bus
);
  localparam int PTR_W = $clog2(WB_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int WA_W  = ADDR_W - 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    RESP = 2'd3
  } state_t;

  state_t            state_q, state_d;

  // Buffer storage carries no reset; occupancy is tracked by count_q alone.
  logic [WA_W-1:0]   wb_addr [WB_DEPTH];
  logic [DATA_W-1:0] wb_data [WB_DEPTH];
  logic [PTR_W-1:0]  head_q, tail_q;
  logic [CNT_W-1:0]  count_q;

  logic              be_req_q, be_req_d;
  logic              be_we_q, be_we_d;
  logic [ADDR_W-1:0] be_addr_q, be_addr_d;
  logic [DATA_W-1:0] be_wdata_q, be_wdata_d;
  logic [DATA_W-1:0] result_q;

  logic [WA_W-1:0]   req_waddr;
  logic              wb_full;
  logic              wr_req, rd_req;
  logic              push, pop, latch_rd;
  logic              fwd_hit;
  logic [DATA_W-1:0] fwd_data;
  logic [PTR_W-1:0]  fwd_idx;
  logic              rd_hit, rd_miss;
  logic              ready_c;

  // Byte-lane bits are irrelevant to word-granular buffering.
  logic              unused_addr_lsbs;
  assign unused_addr_lsbs = ^bus.address[1:0];

  assign req_waddr = bus.address[ADDR_W-1:2];
  assign wb_full   = (count_q == CNT_W'(WB_DEPTH));

  // A simultaneous read and write is a store; the read is dropped.
  assign wr_req = bus.mem_write;
  assign rd_req = bus.mem_read & ~bus.mem_write;

  // Fullness is judged on the occupancy at the start of the cycle, so a pop
  // landing on the same edge never admits a push.
  assign push = wr_req & ~wb_full;

  // Scan entries from oldest to youngest; a later match overwrites an
  // earlier one, so the youngest store to the word wins.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    fwd_idx  = '0;
    for (int i = 0; i < WB_DEPTH; i++) begin
      fwd_idx = head_q + PTR_W'(i);
      if ((CNT_W'(i) < count_q) && (wb_addr[fwd_idx] == req_waddr)) begin
        fwd_hit  = 1'b1;
        fwd_data = wb_data[fwd_idx];
      end
    end
  end

  assign rd_hit  = rd_req & fwd_hit;
  assign rd_miss = rd_req & ~fwd_hit;

  // While a load misses, the pipeline stays frozen, so no store can enter the
  // buffer until RESP releases it.
  always_comb begin
    ready_c = 1'b1;
    if (wr_req) begin
      ready_c = ~wb_full;
    end else if (rd_req) begin
      ready_c = rd_hit | (state_q == RESP);
    end
  end

  assign bus.ready      = ready_c;
  assign bus.mem_result = (state_q != RESP && rd_hit) ? fwd_data : result_q;

  // Backend sequencing. The be_* registers are only reloaded when a new
  // request is launched from IDLE, so they stay stable until be_ack.
  always_comb begin
    state_d    = state_q;
    be_req_d   = be_req_q;
    be_we_d    = be_we_q;
    be_addr_d  = be_addr_q;
    be_wdata_d = be_wdata_q;
    pop        = 1'b0;
    latch_rd   = 1'b0;
    case (state_q)
      IDLE: begin
        // Reads jump ahead of queued stores. A miss never aliases a buffered
        // word, so reordering is safe.
        if (rd_miss) begin
          state_d   = RD;
          be_req_d  = 1'b1;
          be_we_d   = 1'b0;
          be_addr_d = {req_waddr, 2'b00};
        end else if (count_q != '0) begin
          state_d    = WR;
          be_req_d   = 1'b1;
          be_we_d    = 1'b1;
          be_addr_d  = {wb_addr[head_q], 2'b00};
          be_wdata_d = wb_data[head_q];
        end
      end
      RD: begin
        if (bus.be_ack) begin
          latch_rd = 1'b1;
          be_req_d = 1'b0;
          state_d  = RESP;
        end
      end
      WR: begin
        if (bus.be_ack) begin
          pop      = 1'b1;
          be_req_d = 1'b0;
          state_d  = IDLE;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      be_req_q   <= 1'b0;
      be_we_q    <= 1'b0;
      be_addr_q  <= '0;
      be_wdata_q <= '0;
      result_q   <= '0;
    end else begin
      be_req_q   <= be_req_d;
      be_we_q    <= be_we_d;
      be_addr_q  <= be_addr_d;
      be_wdata_q <= be_wdata_d;
      if (latch_rd) begin
        result_q <= bus.be_rdata;
      end
    end
  end

  // Pointers wrap naturally because WB_DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) begin
        tail_q <= tail_q + PTR_W'(1);
      end
      if (pop) begin
        head_q <= head_q + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      wb_addr[tail_q] <= req_waddr;
      wb_data[tail_q] <= bus.data;
    end
  end

  assign bus.be_req   = be_req_q;
  assign bus.be_we    = be_we_q;
  assign bus.be_addr  = be_addr_q;
  assign bus.be_wdata = be_wdata_q;
  assign bus.wb_count = count_q;
  assign bus.wb_empty = (count_q == '0);
endmodule

// File: tb/tb_mem_stage_wbuf.sv
// tb/tb_mem_stage_wbuf.sv - directed self-checking bench for mem_stage_wbuf
module tb_mem_stage_wbuf;
  localparam int ADDR_W   = 32;
  localparam int DATA_W   = 32;
  localparam int WB_DEPTH = 4;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  mem_stage_wbuf_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .WB_DEPTH(WB_DEPTH)) bus ();

  mem_stage_wbuf #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .WB_DEPTH(WB_DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  task automatic idle_inputs();
    bus.mem_read  = 1'b0;
    bus.mem_write = 1'b0;
    bus.address   = '0;
    bus.data      = '0;
    bus.be_ack    = 1'b0;
    bus.be_rdata  = '0;
  endtask

  task automatic drive_write(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    bus.mem_read  = 1'b0;
    bus.mem_write = 1'b1;
    bus.address   = a;
    bus.data      = d;
  endtask

  // Acks every backend request one cycle after it is seen, until the buffer is empty.
  task automatic drain();
    for (int i = 0; i < 200 && bus.wb_empty !== 1'b1; i++) begin
      @(negedge clk);
      if (bus.be_req === 1'b1 && bus.be_ack === 1'b0) bus.be_ack = 1'b1;
      else bus.be_ack = 1'b0;
    end
    @(negedge clk);
    bus.be_ack = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    total++; if (bus.ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%0h exp=1", bus.ready); end
    total++; if (bus.be_req !== 1'b0) begin bad++; $display("FAIL reset_be_req got=%0h exp=0", bus.be_req); end
    total++; if (bus.be_we !== 1'b0) begin bad++; $display("FAIL reset_be_we got=%0h exp=0", bus.be_we); end
    total++; if (bus.be_addr !== 32'h0) begin bad++; $display("FAIL reset_be_addr got=%0h exp=0", bus.be_addr); end
    total++; if (bus.be_wdata !== 32'h0) begin bad++; $display("FAIL reset_be_wdata got=%0h exp=0", bus.be_wdata); end
    total++; if (bus.mem_result !== 32'h0) begin bad++; $display("FAIL reset_mem_result got=%0h exp=0", bus.mem_result); end
    total++; if (bus.wb_count !== 3'd0) begin bad++; $display("FAIL reset_wb_count got=%0d exp=0", bus.wb_count); end
    total++; if (bus.wb_empty !== 1'b1) begin bad++; $display("FAIL reset_wb_empty got=%0h exp=1", bus.wb_empty); end
  endtask

  task automatic test_reset_mid_wr();
    drive_write(32'h100, 32'h1);
    @(negedge clk);
    idle_inputs();
    for (int i = 0; i < 10 && bus.be_req !== 1'b1; i++) @(negedge clk);
    total++; if (bus.be_req !== 1'b1) begin bad++; $display("FAIL rmw_req_up got=%0h exp=1", bus.be_req); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    total++; if (bus.be_req !== 1'b0) begin bad++; $display("FAIL rmw_be_req got=%0h exp=0", bus.be_req); end
    total++; if (bus.wb_count !== 3'd0) begin bad++; $display("FAIL rmw_wb_count got=%0d exp=0", bus.wb_count); end
    total++; if (bus.wb_empty !== 1'b1) begin bad++; $display("FAIL rmw_wb_empty got=%0h exp=1", bus.wb_empty); end
    total++; if (bus.ready !== 1'b1) begin bad++; $display("FAIL rmw_ready got=%0h exp=1", bus.ready); end
  endtask

  task automatic test_fill();
    for (int i = 0; i < 4; i++) begin
      drive_write(32'h10 + 32'(4 * i), 32'h100 + 32'(i));
      #1;
      total++; if (bus.ready !== 1'b1) begin bad++; $display("FAIL fill_ready_%0d got=%0h exp=1", i, bus.ready); end
    end
    drive_write(32'h30, 32'h555);
    #1;
    total++; if (bus.wb_count !== 3'd4) begin bad++; $display("FAIL fill_count4 got=%0d exp=4", bus.wb_count); end
    total++; if (bus.ready !== 1'b0) begin bad++; $display("FAIL fill_full_ready got=%0h exp=0", bus.ready); end
    total++; if (bus.be_req !== 1'b1 || bus.be_we !== 1'b1) begin bad++; $display("FAIL fill_wr_req got=%0h/%0h exp=1/1", bus.be_req, bus.be_we); end
    total++; if (bus.be_addr !== 32'h10) begin bad++; $display("FAIL fill_head_addr got=%0h exp=10", bus.be_addr); end
    total++; if (bus.be_wdata !== 32'h100) begin bad++; $display("FAIL fill_head_data got=%0h exp=100", bus.be_wdata); end
    @(negedge clk);
    #1;
    total++; if (bus.ready !== 1'b0) begin bad++; $display("FAIL fill_stall got=%0h exp=0", bus.ready); end
    bus.be_ack = 1'b1;
    #1;
    total++; if (bus.ready !== 1'b0) begin bad++; $display("FAIL fill_stall_on_ack got=%0h exp=0", bus.ready); end
    @(negedge clk);
    bus.be_ack = 1'b0;
    #1;
    total++; if (bus.be_req !== 1'b0) begin bad++; $display("FAIL fill_req_drop got=%0h exp=0", bus.be_req); end
    total++; if (bus.wb_count !== 3'd3) begin bad++; $display("FAIL fill_after_pop got=%0d exp=3", bus.wb_count); end
    total++; if (bus.ready !== 1'b1) begin bad++; $display("FAIL fill_accept got=%0h exp=1", bus.ready); end
    @(negedge clk);
    idle_inputs();
    #1;
    total++; if (bus.wb_count !== 3'd4) begin bad++; $display("FAIL fill_refill got=%0d exp=4", bus.wb_count); end
    total++; if (bus.be_addr !== 32'h14 || bus.be_req !== 1'b1) begin bad++; $display("FAIL fill_next_head got=%0h/%0h exp=14/1", bus.be_addr, bus.be_req); end
    drain();
    total++; if (bus.wb_empty !== 1'b1) begin bad++; $display("FAIL fill_drained got=%0h exp=1", bus.wb_empty); end
  endtask

  task automatic test_forward();
    drive_write(32'h40, 32'hAAAA);
    drive_write(32'h40, 32'hBBBB);
    @(negedge clk);
    bus.mem_write = 1'b0;
    bus.mem_read  = 1'b1;
    bus.address   = 32'h42;
    #1;
    total++; if (bus.ready !== 1'b1) begin bad++; $display("FAIL fwd_ready got=%0h exp=1", bus.ready); end
    total++; if (bus.mem_result !== 32'hBBBB) begin bad++; $display("FAIL fwd_youngest got=%0h exp=bbbb", bus.mem_result); end
    @(negedge clk);
    idle_inputs();
    #1;
    total++; if ((bus.be_req & ~bus.be_we) !== 1'b0) begin bad++; $display("FAIL fwd_no_be_read got=%0h exp=0", bus.be_req & ~bus.be_we); end
    total++; if (bus.be_addr !== 32'h40 || bus.be_wdata !== 32'hAAAA) begin bad++; $display("FAIL fwd_oldest_drains got=%0h:%0h exp=40:aaaa", bus.be_addr, bus.be_wdata); end
    drain();
    total++; if (bus.wb_count !== 3'd0) begin bad++; $display("FAIL fwd_drained got=%0d exp=0", bus.wb_count); end
  endtask

  task automatic test_read_during_wr();
    drive_write(32'h60, 32'h1);
    drive_write(32'h64, 32'h2);
    drive_write(32'h68, 32'h3);
    @(negedge clk);
    bus.mem_write = 1'b0;
    bus.mem_read  = 1'b1;
    bus.address   = 32'h80;
    #1;
    total++; if (bus.ready !== 1'b0) begin bad++; $display("FAIL rdw_miss_ready got=%0h exp=0", bus.ready); end
    total++; if (bus.be_we !== 1'b1 || bus.be_addr !== 32'h60) begin bad++; $display("FAIL rdw_wr_first got=%0h:%0h exp=1:60", bus.be_we, bus.be_addr); end
    @(negedge clk);
    bus.be_ack = 1'b1;
    @(negedge clk);
    bus.be_ack = 1'b0;
    #1;
    total++; if (bus.be_req !== 1'b0 || bus.ready !== 1'b0) begin bad++; $display("FAIL rdw_gap got=%0h/%0h exp=0/0", bus.be_req, bus.ready); end
    total++; if (bus.wb_count !== 3'd2) begin bad++; $display("FAIL rdw_count got=%0d exp=2", bus.wb_count); end
    @(negedge clk);
    #1;
    total++; if (bus.be_req !== 1'b1 || bus.be_we !== 1'b0 || bus.be_addr !== 32'h80) begin bad++; $display("FAIL rdw_rd_next got=%0h/%0h/%0h exp=1/0/80", bus.be_req, bus.be_we, bus.be_addr); end
    bus.be_ack   = 1'b1;
    bus.be_rdata = 32'hCAFE0080;
    @(negedge clk);
    bus.be_ack   = 1'b0;
    bus.be_rdata = 32'h0;
    #1;
    total++; if (bus.ready !== 1'b1) begin bad++; $display("FAIL rdw_resp_ready got=%0h exp=1", bus.ready); end
    total++; if (bus.mem_result !== 32'hCAFE0080) begin bad++; $display("FAIL rdw_resp_data got=%0h exp=cafe0080", bus.mem_result); end
    bus.mem_read = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    total++; if (bus.be_req !== 1'b1 || bus.be_we !== 1'b1 || bus.be_addr !== 32'h64) begin bad++; $display("FAIL rdw_resume got=%0h/%0h/%0h exp=1/1/64", bus.be_req, bus.be_we, bus.be_addr); end
    drain();
    total++; if (bus.wb_empty !== 1'b1) begin bad++; $display("FAIL rdw_drained got=%0h exp=1", bus.wb_empty); end
  endtask

  task automatic test_read_miss_latency();
    int low;
    low = 0;
    @(negedge clk);
    bus.mem_read = 1'b1;
    bus.address  = 32'h93;
    #1;
    if (bus.ready === 1'b0) low++;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      if (k == 1) begin
        #1;
        total++; if (bus.be_req !== 1'b1 || bus.be_addr !== 32'h90) begin bad++; $display("FAIL lat_req got=%0h:%0h exp=1:90", bus.be_req, bus.be_addr); end
      end
      if (k == 3) begin
        bus.be_ack   = 1'b1;
        bus.be_rdata = 32'h12345678;
      end
      #1;
      if (bus.ready === 1'b0) low++;
    end
    total++; if (low != 4) begin bad++; $display("FAIL lat_low_cycles got=%0d exp=4", low); end
    @(negedge clk);
    bus.be_ack   = 1'b0;
    bus.be_rdata = 32'h0;
    #1;
    total++; if (bus.ready !== 1'b1) begin bad++; $display("FAIL lat_resp_ready got=%0h exp=1", bus.ready); end
    total++; if (bus.mem_result !== 32'h12345678) begin bad++; $display("FAIL lat_resp_data got=%0h exp=12345678", bus.mem_result); end
    bus.mem_read = 1'b0;
    @(negedge clk);
    #1;
    total++; if (bus.be_req !== 1'b0 || bus.ready !== 1'b1) begin bad++; $display("FAIL lat_after got=%0h/%0h exp=0/1", bus.be_req, bus.ready); end
  endtask

  task automatic test_read_write_both();
    @(negedge clk);
    bus.mem_read  = 1'b1;
    bus.mem_write = 1'b1;
    bus.address   = 32'h20;
    bus.data      = 32'h6666;
    #1;
    total++; if (bus.ready !== 1'b1) begin bad++; $display("FAIL both_ready got=%0h exp=1", bus.ready); end
    @(negedge clk);
    idle_inputs();
    #1;
    total++; if (bus.wb_count !== 3'd1) begin bad++; $display("FAIL both_pushed got=%0d exp=1", bus.wb_count); end
    total++; if (bus.be_req !== 1'b0) begin bad++; $display("FAIL both_no_read got=%0h exp=0", bus.be_req); end
    @(negedge clk);
    #1;
    total++; if (bus.be_req !== 1'b1 || bus.be_we !== 1'b1 || bus.be_addr !== 32'h20 || bus.be_wdata !== 32'h6666) begin bad++; $display("FAIL both_drain got=%0h/%0h/%0h/%0h exp=1/1/20/6666", bus.be_req, bus.be_we, bus.be_addr, bus.be_wdata); end
    drain();
    total++; if (bus.wb_empty !== 1'b1) begin bad++; $display("FAIL both_drained got=%0h exp=1", bus.wb_empty); end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_reset_mid_wr();
    test_fill();
    test_forward();
    test_read_during_wr();
    test_read_miss_latency();
    test_read_write_both();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
